rob_rewind_walker: RTL

//  Sequencer on the ROB side of the mispredict-recovery path. On a squash it walks ROB entries

---
 rtl/rob_rewind_walker_pkg.sv | 24 ++
 rtl/rob_rewind_walker.sv | 105 ++++++++++
 2 files changed

// File: rtl/rob_rewind_walker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_rewind_walker_pkg
// Description : Shared sizes, types and state encoding for the ROB rewind walker.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_rewind_walker_pkg;

    localparam int WAY         = 2;
    localparam int ROB_SIZE    = 16;
    localparam int ROB_IDX_LEN = $clog2(ROB_SIZE);
    localparam int WAY_CNT_LEN = $clog2(WAY + 1);
    localparam int PHY_REG_LEN = 6;

    typedef logic [PHY_REG_LEN-1:0] phy_reg_idx_t;
    typedef logic [ROB_IDX_LEN-1:0] rob_idx_t;

    typedef enum logic [0:0] {
        RW_IDLE = 1'b0,
        RW_WALK = 1'b1
    } rewind_state_t;

endpackage
`default_nettype wire

// File: rtl/rob_rewind_walker.sv
`default_nettype none
// ============================================================================
// Module      : rob_rewind_walker
// Description : Walks squashed ROB entries youngest-first, WAY per cycle,
//               emitting rewind packets for map table, freelist and RS.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_rewind_walker
    import rob_rewind_walker_pkg::*;
(
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  squash_valid,
    input  logic [ROB_IDX_LEN-1:0]                squash_rob_idx,
    input  logic [ROB_IDX_LEN-1:0]                rob_tail,
    output logic [WAY-1:0][ROB_IDX_LEN-1:0]       rd_idx,
    input  logic [WAY-1:0][PHY_REG_LEN-1:0]       rd_T,
    input  logic [WAY-1:0][PHY_REG_LEN-1:0]       rd_Told,
    output logic [WAY_CNT_LEN-1:0]                rw_num,
    output logic [WAY-1:0][PHY_REG_LEN-1:0]       rw_reg_T,
    output logic [WAY-1:0][PHY_REG_LEN-1:0]       rw_reg_Told,
    output logic [WAY-1:0][ROB_IDX_LEN-1:0]       rw_rob_index,
    output logic                                  rw_busy,
    output logic                                  rw_last,
    output logic [ROB_IDX_LEN-1:0]                rw_new_tail
);

    rewind_state_t          r_state,   w_state_next;
    logic [ROB_IDX_LEN-1:0] r_cur_idx, w_cur_idx_next;
    logic [ROB_IDX_LEN-1:0] r_br_idx,  w_br_idx_next;
    logic [ROB_IDX_LEN:0]   r_remain,  w_remain_next;

    logic [ROB_IDX_LEN-1:0] w_squash_remain;
    logic [WAY_CNT_LEN-1:0] w_n;
    logic                   w_walk;
    logic                   w_last;

    assign w_walk          = (r_state == RW_WALK);
    assign w_last          = (r_remain <= (ROB_IDX_LEN+1)'(WAY));
    assign w_n             = w_last ? r_remain[WAY_CNT_LEN-1:0] : WAY_CNT_LEN'(WAY);
    // Entries strictly between the branch and the tail; wraps naturally at ROB_IDX_LEN bits.
    assign w_squash_remain = rob_tail - squash_rob_idx - ROB_IDX_LEN'(1);

    always_comb begin
        w_state_next   = r_state;
        w_cur_idx_next = r_cur_idx;
        w_br_idx_next  = r_br_idx;
        w_remain_next  = r_remain;
        case (r_state)
            RW_IDLE: begin
                if (squash_valid) begin
                    w_state_next   = RW_WALK;
                    w_cur_idx_next = rob_tail - ROB_IDX_LEN'(1);
                    w_br_idx_next  = squash_rob_idx;
                    w_remain_next  = {1'b0, w_squash_remain};
                end
            end
            RW_WALK: begin
                w_cur_idx_next = r_cur_idx - ROB_IDX_LEN'(w_n);
                w_remain_next  = r_remain - (ROB_IDX_LEN+1)'(w_n);
                if (w_last) begin
                    w_state_next = RW_IDLE;
                end
            end
            default: w_state_next = RW_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= RW_IDLE;
            r_cur_idx <= '0;
            r_br_idx  <= '0;
            r_remain  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cur_idx <= w_cur_idx_next;
            r_br_idx  <= w_br_idx_next;
            r_remain  <= w_remain_next;
        end
    end

    always_comb begin
        rw_busy     = w_walk;
        rw_last     = w_walk && w_last;
        rw_num      = w_walk ? w_n : '0;
        rw_new_tail = (w_walk && w_last) ? (r_br_idx + ROB_IDX_LEN'(1)) : '0;
    end

    // Slot 0 is the youngest entry; unused slots are forced to zero.
    for (genvar i = 0; i < WAY; i++) begin : g_slot
        logic w_slot_vld;
        assign w_slot_vld      = w_walk && (WAY_CNT_LEN'(i) < w_n);
        assign rd_idx[i]       = r_cur_idx - ROB_IDX_LEN'(i);
        assign rw_reg_T[i]     = w_slot_vld ? rd_T[i]    : '0;
        assign rw_reg_Told[i]  = w_slot_vld ? rd_Told[i] : '0;
        assign rw_rob_index[i] = w_slot_vld ? rd_idx[i]  : '0;
    end

    a_no_squash_in_walk: assert property (@(posedge clock) disable iff (reset)
        !(squash_valid && w_walk))
        else $warning("squash_valid raised while rewind walk in progress; ignored");

endmodule
`default_nettype wire
